// File: rtl/sort_sched.sv
// sort_sched: shares one combinational 5-input sorting core between two
// requesters (A and B). Round-robin arbitration, registered core operands,
// a programmable settle window before the ranks are captured, and a
// valid/ready response channel tagged with the winning requester.
//
// Optional build macro SORT_SCHED_RANK_CHECK_EN: when defined, resp_err
// flags captured ranks that are not a permutation of 0..4. When undefined,
// resp_err is constant 0.
module sort_sched #(
    parameter int W             = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid_a,
    input  logic [5*W-1:0] req_data_a,
    output logic           req_ready_a,
    input  logic           req_valid_b,
    input  logic [5*W-1:0] req_data_b,
    output logic           req_ready_b,
    output logic [W-1:0]   core_i0,
    output logic [W-1:0]   core_i1,
    output logic [W-1:0]   core_i2,
    output logic [W-1:0]   core_i3,
    output logic [W-1:0]   core_i4,
    input  logic [W-1:0]   core_rank0,
    input  logic [W-1:0]   core_rank1,
    input  logic [W-1:0]   core_rank2,
    input  logic [W-1:0]   core_rank3,
    input  logic [W-1:0]   core_rank4,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [5*W-1:0] resp_rank,
    output logic           resp_err,
    output logic           busy,
    output logic [15:0]    job_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state_reg;
    logic [3:0]     cnt_reg;
    logic           last_grant_reg;   // 1 = B was served last
    logic [W-1:0]   core_in_reg [5];
    logic [5*W-1:0] rank_reg;
    logic           resp_id_reg;
    logic           resp_err_reg;
    logic           resp_valid_reg;
    logic [15:0]    job_cnt_reg;

    logic           grant_b;
    logic           accept;
    logic [5*W-1:0] grant_data;
    logic [5*W-1:0] rank_bus;
    logic           rank_bad;

    assign rank_bus = {core_rank4, core_rank3, core_rank2, core_rank1, core_rank0};

    // Round-robin grant: a lone requester wins; on a tie, whoever was not served last.
    always_comb begin
        grant_b     = req_valid_b && (!req_valid_a || !last_grant_reg);
        req_ready_a = !rst && (state_reg == IDLE) && req_valid_a && !grant_b;
        req_ready_b = !rst && (state_reg == IDLE) && grant_b;
        accept      = req_ready_a || req_ready_b;
        grant_data  = grant_b ? req_data_b : req_data_a;
    end

`ifdef SORT_SCHED_RANK_CHECK_EN
    // Ranks form a permutation of 0..4 when all are in range and every value 0..4 appears.
    logic [4:0] in_range;
    logic [4:0] present;
    logic [4:0] match [5];

    for (genvar gi = 0; gi < 5; gi++) begin : g_rank_chk
        assign in_range[gi] = (int'(rank_bus[gi*W +: W]) < 5);
        for (genvar gj = 0; gj < 5; gj++) begin : g_match
            assign match[gi][gj] = (int'(rank_bus[gj*W +: W]) == gi);
        end
        assign present[gi] = |match[gi];
    end

    assign rank_bad = !((&in_range) && (&present));
`else
    assign rank_bad = 1'b0;
`endif

    // Controller: accept -> settle window -> hold response until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            for (int k = 0; k < 5; k++) begin
                core_in_reg[k] <= '0;
            end
            rank_reg       <= '0;
            resp_id_reg    <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
            job_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < 5; k++) begin
                            core_in_reg[k] <= grant_data[k*W +: W];
                        end
                        resp_id_reg    <= grant_b;
                        last_grant_reg <= grant_b;
                        cnt_reg        <= 4'(SETTLE_CYCLES);
                        state_reg      <= SETTLE;
                    end
                end
                SETTLE: begin
                    // The edge that would take the counter to zero is the capture edge.
                    if (cnt_reg == 4'd1) begin
                        rank_reg       <= rank_bus;
                        resp_err_reg   <= rank_bad;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        job_cnt_reg    <= job_cnt_reg + 16'd1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign core_i0    = core_in_reg[0];
    assign core_i1    = core_in_reg[1];
    assign core_i2    = core_in_reg[2];
    assign core_i3    = core_in_reg[3];
    assign core_i4    = core_in_reg[4];
    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_rank  = rank_reg;
    assign resp_err   = resp_err_reg;
    assign busy       = (state_reg != IDLE);
    assign job_cnt    = job_cnt_reg;

endmodule

// File: doc/sort_sched.md
Name: sort_sched

Overview:
- Sequential controller that shares one combinational 5-input `sorting` core between two requesters, A and B.
- Arbitrates round-robin between A and B and registers the 5 granted operands onto the core inputs.
- Waits a programmable number of settle cycles, because the core is treated as a multicycle path.
- Captures rank0..rank4 and returns them to the winner over a valid/ready response channel, tagged with the requester ID.

Parameters:
- W, 6: operand and rank width in bits.
- SETTLE_CYCLES, 2: clock edges from driving the core inputs to capturing the core outputs. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_a  in  1  requester A has a job.
- req_data_a  in  5*W  A operands; [W-1:0]=i0 … [5W-1:4W]=i4.
- req_ready_a  out  1  A job accepted on this edge.
- req_valid_b  in  1  requester B has a job.
- req_data_b  in  5*W  B operands, packed as for A.
- req_ready_b  out  1  B job accepted on this edge.
- core_i0..core_i4  out  W each  registered operands to the sorting core.
- core_rank0..core_rank4  in  W each  combinational ranks from the core.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  1  0=A, 1=B.
- resp_rank  out  5*W  captured ranks, packed like the request.
- resp_err  out  1  permutation-check failure (see Optional Feature).
- busy  out  1  high whenever state != IDLE.
- job_cnt  out  16  number of completed responses; wraps at 0xFFFF→0.

Behaviour:
- States and transitions:
  - IDLE → SETTLE on accept.
  - SETTLE → RESP when the settle counter expires.
  - RESP → IDLE on resp_valid && resp_ready.
- Grant (combinational, IDLE only):
  - Only one valid: grant it.
  - Both valid: grant the requester not served last.
  - last_grant resets to B, so A wins the first tie.
- Ready outputs: req_ready_x = (state==IDLE) && grant==x. Requests are never accepted in SETTLE or RESP.
- Accept edge E0:
  - Latch the granted request data into core_i0..4.
  - Latch resp_id and update last_grant.
  - Load the counter with SETTLE_CYCLES.
  - Go to SETTLE.
- SETTLE:
  - Counter decrements each edge.
  - At edge E0+SETTLE_CYCLES, capture core_rank0..4 into resp_rank and go to RESP.
  - resp_valid is high from that edge.
- Response latency: from the accept edge to resp_valid = SETTLE_CYCLES clocks exactly.
- RESP:
  - resp_valid, resp_id, resp_rank and resp_err are held stable until resp_ready is sampled high.
  - On that edge: return to IDLE, increment job_cnt, deassert resp_valid.
- Back-to-back jobs: the earliest next accept is the edge after the response handshake, since req_ready only asserts in IDLE. Minimum job period is SETTLE_CYCLES+2 clocks.
- Operand hold: core_i0..4 hold their value after capture until the next accept. They are not cleared on return to IDLE.
- Reset (synchronous; also applies mid-job):
  - state=IDLE, last_grant=B.
  - core_i*=0, resp_rank=0, resp_id=0, resp_err=0, resp_valid=0, job_cnt=0.
  - req_ready_* are low during the rst cycle.
  - Any in-flight job is dropped; no response is produced for it.
- Data path: no arithmetic on operands or ranks. Ranks pass through unmodified at width W.

Optional Feature:
- Macro: SORT_SCHED_RANK_CHECK_EN.
- When defined: at the capture edge, resp_err is set if the five captured ranks are not exactly a permutation of 0..4. This includes any rank > 4 and any duplicate. The result is still delivered; resp_err is held with resp_valid.
- When undefined: resp_err is tied 0 and no check logic is synthesised.

Test Plan (bench core model: rank = count of smaller operands, ties broken by lower index):
- Single A job, SETTLE_CYCLES=2, data {i0..i4}={05,01,3F,10,00}:
  - req_ready_a pulses once.
  - resp_valid rises 2 clocks later with ranks {2,1,4,3,0}, resp_id=0, job_cnt 0→1 after the handshake.
- A and B both valid continuously for 4 jobs:
  - Grant order A,B,A,B.
  - Then drop A: B is granted twice in a row.
- Response backpressure: resp_ready held low 5 clocks.
  - resp_valid and resp_rank stay stable.
  - req_ready_a/b stay low.
  - The job completes on the first resp_ready=1 edge.
- Reset mid-SETTLE: rst for 1 cycle at E0+1.
  - No resp_valid appears.
  - All outputs are 0, job_cnt=0.
  - The next simultaneous A/B request grants A.
- SETTLE_CYCLES=1 and 15: measure accept→resp_valid = 1 and 15 clocks respectively.
- With SORT_SCHED_RANK_CHECK_EN, core model forced to ranks {0,0,1,2,3}: resp_err=1. Ranks {4,3,2,1,0}: resp_err=0.
- job_cnt wrap: preload via 65536 jobs (or force), confirm 0xFFFF→0x0000.
